digit_step_counter: RTL and testbench

- Upstream feeder for the 3-bit seven-segment decoder.
- Turns two raw push-buttons (up/down) into a debounced, single-step, wrapping 0..7 value. That value drives the decoder's 3-bit `in` directly.
- Inputs are synchronised, debounced and edge-detected, so one physical press gives exactly one count step.

---
 rtl/digit_step_counter_pkg.sv | 35 +++
 rtl/digit_step_counter_btn_debounce.sv | 64 ++++++
 rtl/digit_step_counter.sv | 107 ++++++++++
 tb/tb_digit_step_counter.sv | 348 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/digit_step_counter_pkg.sv
// Shared types and constants for the push-button digit step counter.
package digit_step_counter_pkg;

   // Width of the seven-segment decoder input that the count drives.
   localparam int COUNT_W = 3;

   // Default number of consecutive stable synchronised samples before a
   // debounced level is allowed to flip.
   localparam int DEBOUNCE_CYCLES_DEF = 4;

   // Debounce counter width; wide enough for the largest supported
   // debounce length (65535).
   localparam int DB_CNT_W = 16;

   typedef logic [COUNT_W-1:0] count_t;

   // Net direction requested by the step pulses in a given cycle.
   typedef enum logic [1:0] {
      STEP_NONE = 2'd0,
      STEP_UP   = 2'd1,
      STEP_DOWN = 2'd2
   } step_dir_t;

   // Up and down pulses on the same cycle cancel each other out.
   function automatic step_dir_t resolve_step(input logic up, input logic down);
      if (up && !down) begin
         return STEP_UP;
      end else if (down && !up) begin
         return STEP_DOWN;
      end else begin
         return STEP_NONE;
      end
   endfunction

endpackage : digit_step_counter_pkg

// File: rtl/digit_step_counter_btn_debounce.sv
// One raw push-button -> synchronised, debounced, single-cycle rising-edge
// pulse. A press is reported once; releasing is filtered the same way so
// release bounce can never look like a new press.
module btn_debounce
   import digit_step_counter_pkg::*;
#(
   parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF
) (
   input  logic clk,
   input  logic rst_n,
   input  logic raw,
   output logic rise
);

   localparam logic [DB_CNT_W-1:0] LAST_CNT = DB_CNT_W'(DEBOUNCE_CYCLES - 1);

   logic [1:0]          sync_q;
   logic                sample;
   logic                db_level;
   logic                db_level_prev;
   logic [DB_CNT_W-1:0] db_cnt;

   assign sample = sync_q[1];

   // Two-flop synchroniser: sample is the raw button as seen two edges ago.
   // NOTE: non-blocking (<=) in clocked blocks so every flop samples the
   // pre-edge value of its neighbour; blocking here would collapse the chain.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         sync_q <= '0;
      end else begin
         sync_q <= {sync_q[0], raw};
      end
   end

   // Debounce: count consecutive samples that disagree with the level, any
   // agreeing sample restarts the count, and the level flips once enough
   // disagreeing samples have been seen in a row.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         db_level <= 1'b0;
         db_cnt   <= '0;
      end else if (sample == db_level) begin
         db_cnt <= '0;
      end else if (db_cnt == LAST_CNT) begin
         db_level <= sample;
         db_cnt   <= '0;
      end else begin
         db_cnt <= db_cnt + 1'b1;
      end
   end

   // Registered rising-edge detect on the debounced level; falls are ignored.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         db_level_prev <= 1'b0;
         rise          <= 1'b0;
      end else begin
         db_level_prev <= db_level;
         rise          <= db_level & ~db_level_prev;
      end
   end

endmodule : btn_debounce

// File: rtl/digit_step_counter.sv
// Up/down push-button counter wrapping over 0..MAX_VAL, feeding the 3-bit
// seven-segment decoder. Buttons are cleaned by two btn_debounce instances;
// this level only resolves clear/enable/step priority and holds the outputs.
module digit_step_counter
   import digit_step_counter_pkg::*;
#(
   parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF,
   parameter int MAX_VAL         = 7,
   parameter int INIT_VAL        = 0
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic               btn_up,
   input  logic               btn_down,
   input  logic               en,
   input  logic               clear,
   output logic [COUNT_W-1:0] count,
   output logic               changed,
   output logic               wrap
);

   localparam count_t MAX_C  = count_t'(MAX_VAL);
   localparam count_t INIT_C = count_t'(INIT_VAL);

   logic      up_rise;
   logic      down_rise;
   step_dir_t step_dir;
   count_t    count_nxt;
   logic      changed_nxt;
   logic      wrap_nxt;

   btn_debounce #(
      .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
   ) u_db_up (
      .clk   (clk),
      .rst_n (rst_n),
      .raw   (btn_up),
      .rise  (up_rise)
   );

   btn_debounce #(
      .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
   ) u_db_down (
      .clk   (clk),
      .rst_n (rst_n),
      .raw   (btn_down),
      .rise  (down_rise)
   );

   // Net step direction for this cycle; simultaneous up and down cancel.
   always_comb begin
      step_dir = resolve_step(up_rise, down_rise);
   end

   // Priority resolver: clear beats enable, enable gates the step pulses
   // (they are dropped, never queued), then the step wraps at either end.
   // NOTE: every output of this block gets a default first, so no path
   // leaves a value unassigned and no latch is inferred.
   always_comb begin
      count_nxt   = count;
      changed_nxt = 1'b0;
      wrap_nxt    = 1'b0;
      if (clear) begin
         count_nxt   = INIT_C;
         changed_nxt = (count != INIT_C);
      end else if (en) begin
         case (step_dir)
            STEP_UP: begin
               changed_nxt = 1'b1;
               if (count == MAX_C) begin
                  count_nxt = '0;
                  wrap_nxt  = 1'b1;
               end else begin
                  count_nxt = count + 1'b1;
               end
            end
            STEP_DOWN: begin
               changed_nxt = 1'b1;
               if (count == '0) begin
                  count_nxt = MAX_C;
                  wrap_nxt  = 1'b1;
               end else begin
                  count_nxt = count - 1'b1;
               end
            end
            default: begin
               count_nxt = count;
            end
         endcase
      end
   end

   // Output registers: changed and wrap are single-cycle pulses aligned with
   // the edge that loads the new count.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         count   <= INIT_C;
         changed <= 1'b0;
         wrap    <= 1'b0;
      end else begin
         count   <= count_nxt;
         changed <= changed_nxt;
         wrap    <= wrap_nxt;
      end
   end

endmodule : digit_step_counter

// File: tb/tb_digit_step_counter.sv
// Self-checking bench for digit_step_counter: directed scenarios with fixed
// expected values, then a randomized run against a window-based reference.
module tb_digit_step_counter;

   localparam int D     = 4;
   localparam int MAXV  = 7;
   localparam int INITV = 0;
   localparam int N     = 8192;

   logic       clk = 1'b0;
   logic       rst_n;
   logic       btn_up;
   logic       btn_down;
   logic       en;
   logic       clear;
   logic [2:0] count;
   logic       changed;
   logic       wrap;

   int vectors     = 0;
   int miscompares = 0;
   int chg_seen    = 0;
   int wrap_seen   = 0;

   // Reference model state: raw input history per edge, debounced level,
   // edge of last level flip, and which edges produced a rising level.
   bit raw_h  [2][N];
   bit rise_h [2][N];
   bit lvl    [2];
   int lf     [2];
   int n        = 0;
   int rst_edge = 0;
   int m_count  = 0;
   bit m_changed;
   bit m_wrap;

   digit_step_counter #(
      .DEBOUNCE_CYCLES (D),
      .MAX_VAL         (MAXV),
      .INIT_VAL        (INITV)
   ) dut (
      .clk      (clk),
      .rst_n    (rst_n),
      .btn_up   (btn_up),
      .btn_down (btn_down),
      .en       (en),
      .clear    (clear),
      .count    (count),
      .changed  (changed),
      .wrap     (wrap)
   );

   always #5 clk = ~clk;

   initial begin
      #400000;
      $display("FAIL timeout: simulation still running at %0t, required to finish earlier", $time);
      $fatal(1);
   end

   // Synchronised sample of button b at edge k: raw two edges earlier, and
   // zero while the synchroniser is still refilling after a reset.
   function automatic bit samp(input int b, input int k);
      if (k - rst_edge >= 3) return raw_h[b][k-2];
      return 1'b0;
   endfunction

   // Advance the reference by one clock edge using the inputs at that edge.
   task automatic model_step();
      bit p_up;
      bit p_dn;
      bit all_diff;
      n++;
      if (n >= N) begin
         $display("FAIL model_capacity: edge %0d, required below %0d", n, N);
         $fatal(1);
      end
      raw_h[0][n]  = btn_up;
      raw_h[1][n]  = btn_down;
      rise_h[0][n] = 1'b0;
      rise_h[1][n] = 1'b0;
      if (!rst_n) begin
         rst_edge  = n;
         lvl[0]    = 1'b0;
         lvl[1]    = 1'b0;
         lf[0]     = n;
         lf[1]     = n;
         m_count   = INITV;
         m_changed = 1'b0;
         m_wrap    = 1'b0;
         return;
      end
      // Level flips when the last D samples since the previous flip all
      // disagree with it.
      for (int b = 0; b < 2; b++) begin
         if (n - lf[b] >= D) begin
            all_diff = 1'b1;
            for (int k = n - D + 1; k <= n; k++) begin
               if (samp(b, k) == lvl[b]) all_diff = 1'b0;
            end
            if (all_diff) begin
               lvl[b]       = ~lvl[b];
               lf[b]        = n;
               rise_h[b][n] = lvl[b];
            end
         end
      end
      // A rising level acts on the count two edges later.
      p_up = (n - 2 > rst_edge) && rise_h[0][n-2];
      p_dn = (n - 2 > rst_edge) && rise_h[1][n-2];
      m_changed = 1'b0;
      m_wrap    = 1'b0;
      if (clear) begin
         m_changed = (m_count != INITV);
         m_count   = INITV;
      end else if (en && (p_up != p_dn)) begin
         m_changed = 1'b1;
         if (p_up) begin
            if (m_count == MAXV) begin
               m_count = 0;
               m_wrap  = 1'b1;
            end else begin
               m_count = m_count + 1;
            end
         end else begin
            if (m_count == 0) begin
               m_count = MAXV;
               m_wrap  = 1'b1;
            end else begin
               m_count = m_count - 1;
            end
         end
      end
   endtask

   // One clock edge: update the reference on the edge, then let outputs
   // settle before anyone looks at them.
   task automatic tick();
      @(posedge clk);
      model_step();
      #1;
      if (changed === 1'b1) chg_seen++;
      if (wrap === 1'b1) wrap_seen++;
   endtask

   task automatic press(input bit up, input bit down);
      btn_up   = up;
      btn_down = down;
      repeat (12) tick();
      btn_up   = 1'b0;
      btn_down = 1'b0;
      repeat (12) tick();
   endtask

   task automatic test_reset();
      rst_n = 1'b0; btn_up = 1'b0; btn_down = 1'b0; en = 1'b1; clear = 1'b0;
      repeat (2) tick();
      vectors++;
      if (count !== 3'(INITV) || changed !== 1'b0 || wrap !== 1'b0) begin
         miscompares++;
         $display("FAIL reset_state: count=%0d changed=%b wrap=%b, want %0d/0/0", count, changed, wrap, INITV);
      end
      rst_n = 1'b1;
      for (int i = 0; i < 20; i++) begin
         tick();
         vectors++;
         if (count !== 3'd0 || changed !== 1'b0 || wrap !== 1'b0) begin
            miscompares++;
            $display("FAIL reset_idle[%0d]: count=%0d changed=%b wrap=%b, want 0/0/0", i, count, changed, wrap);
         end
      end
   endtask

   task automatic test_single_press();
      btn_up = 1'b1;
      for (int i = 0; i < 30; i++) begin
         tick();
         vectors++;
         if (count !== ((i >= 7) ? 3'd1 : 3'd0) || changed !== (i == 7)) begin
            miscompares++;
            $display("FAIL single_press[%0d]: count=%0d changed=%b, want %0d/%b", i, count, changed, (i >= 7) ? 1 : 0, (i == 7));
         end
      end
      btn_up = 1'b0;
      chg_seen = 0;
      repeat (20) tick();
      vectors++;
      if (count !== 3'd1 || chg_seen != 0) begin
         miscompares++;
         $display("FAIL single_release: count=%0d changes=%0d, want 1/0", count, chg_seen);
      end
   endtask

   task automatic test_bounce();
      bit pat [4] = '{1'b1, 1'b0, 1'b1, 1'b0};
      chg_seen = 0;
      for (int i = 0; i < 20; i++) begin
         btn_up = (i < 4) ? pat[i] : 1'b1;
         tick();
         vectors++;
         if (count !== ((i >= 11) ? 3'd2 : 3'd1) || changed !== (i == 11)) begin
            miscompares++;
            $display("FAIL bounce[%0d]: count=%0d changed=%b, want %0d/%b", i, count, changed, (i >= 11) ? 2 : 1, (i == 11));
         end
      end
      btn_up = 1'b0;
      repeat (12) tick();
      vectors++;
      if (count !== 3'd2 || chg_seen != 1) begin
         miscompares++;
         $display("FAIL bounce_total: count=%0d changes=%0d, want 2/1", count, chg_seen);
      end
   endtask

   task automatic test_wrap();
      clear = 1'b1; tick(); clear = 1'b0; tick();
      wrap_seen = 0;
      repeat (7) press(1'b1, 1'b0);
      vectors++;
      if (count !== 3'd7 || wrap_seen != 0) begin
         miscompares++;
         $display("FAIL wrap_climb: count=%0d wraps=%0d, want 7/0", count, wrap_seen);
      end
      press(1'b1, 1'b0);
      vectors++;
      if (count !== 3'd0 || wrap_seen != 1) begin
         miscompares++;
         $display("FAIL wrap_up: count=%0d wraps=%0d, want 0/1", count, wrap_seen);
      end
      press(1'b0, 1'b1);
      vectors++;
      if (count !== 3'd7 || wrap_seen != 2) begin
         miscompares++;
         $display("FAIL wrap_down: count=%0d wraps=%0d, want 7/2", count, wrap_seen);
      end
   endtask

   task automatic test_simultaneous();
      chg_seen = 0;
      press(1'b1, 1'b1);
      vectors++;
      if (count !== 3'd7 || chg_seen != 0) begin
         miscompares++;
         $display("FAIL both_pressed: count=%0d changes=%0d, want 7/0", count, chg_seen);
      end
   endtask

   task automatic test_enable();
      chg_seen = 0;
      en = 1'b0;
      press(1'b1, 1'b0);
      vectors++;
      if (count !== 3'd7 || chg_seen != 0) begin
         miscompares++;
         $display("FAIL en_low: count=%0d changes=%0d, want 7/0", count, chg_seen);
      end
      en = 1'b1;
      press(1'b1, 1'b0);
      vectors++;
      if (count !== 3'd0 || chg_seen != 1) begin
         miscompares++;
         $display("FAIL en_high: count=%0d changes=%0d, want 0/1", count, chg_seen);
      end
   endtask

   task automatic test_clear();
      repeat (5) press(1'b1, 1'b0);
      vectors++;
      if (count !== 3'd5) begin
         miscompares++;
         $display("FAIL clear_setup: count=%0d, want 5", count);
      end
      btn_up = 1'b1;
      repeat (7) tick();
      clear = 1'b1;
      tick();
      vectors++;
      if (count !== 3'd0 || changed !== 1'b1 || wrap !== 1'b0) begin
         miscompares++;
         $display("FAIL clear_vs_step: count=%0d changed=%b wrap=%b, want 0/1/0", count, changed, wrap);
      end
      clear = 1'b0;
      tick();
      vectors++;
      if (count !== 3'd0 || changed !== 1'b0) begin
         miscompares++;
         $display("FAIL clear_drop: count=%0d changed=%b, want 0/0", count, changed);
      end
      btn_up = 1'b0;
      repeat (12) tick();
   endtask

   task automatic test_reset_mid_press();
      press(1'b1, 1'b0);
      btn_up = 1'b1;
      repeat (3) tick();
      rst_n = 1'b0;
      tick();
      vectors++;
      if (count !== 3'd0 || changed !== 1'b0) begin
         miscompares++;
         $display("FAIL reset_mid_press: count=%0d changed=%b, want 0/0", count, changed);
      end
      rst_n = 1'b1;
      for (int j = 1; j <= 12; j++) begin
         tick();
         vectors++;
         if (count !== ((j >= 8) ? 3'd1 : 3'd0) || changed !== (j == 8)) begin
            miscompares++;
            $display("FAIL reset_redebounce[%0d]: count=%0d changed=%b, want %0d/%b", j, count, changed, (j >= 8) ? 1 : 0, (j == 8));
         end
      end
      btn_up = 1'b0;
      repeat (12) tick();
   endtask

   task automatic test_random();
      for (int i = 0; i < 2500; i++) begin
         if ($urandom_range(5) == 0) btn_up = ~btn_up;
         if ($urandom_range(6) == 0) btn_down = ~btn_down;
         en    = ($urandom_range(9) != 0);
         clear = ($urandom_range(39) == 0);
         rst_n = ($urandom_range(299) != 0);
         tick();
         vectors++;
         if (count !== 3'(m_count) || changed !== m_changed || wrap !== m_wrap) begin
            miscompares++;
            $display("FAIL random[%0d]: count=%0d changed=%b wrap=%b, want %0d/%b/%b", i, count, changed, wrap, m_count, m_changed, m_wrap);
         end
      end
   endtask

   initial begin
      rst_n = 1'b0; btn_up = 1'b0; btn_down = 1'b0; en = 1'b1; clear = 1'b0;
      test_reset();
      test_single_press();
      test_bounce();
      test_wrap();
      test_simultaneous();
      test_enable();
      test_clear();
      test_reset_mid_press();
      test_random();
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule : tb_digit_step_counter
